// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default sizes and
// program-word field layout (opcode in the low nibble, operand directly above).
package prog_loader_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int W_DEF     = 4;
  localparam int LEN_W     = 5;
  localparam int OPC_LSB   = 0;
  localparam int OPR_LSB   = W_DEF;

  typedef enum logic [2:0] {
    IDLE, COLLECT, CLEAR, BURST, FINISH, RUN
  } state_t;
endpackage

// File: rtl/prog_buffer.sv
// DEPTH x DW program store. count doubles as the write pointer; the read
// pointer walks the stored words during the burst.
module prog_buffer
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = 2 * W_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] rd_ptr
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic          wr_ok;

  assign wr_ok = wr_en && (count < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count  <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) count  <= count + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Contents are left alone by reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[count[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/prog_loader.sv
// Collects a streamed program, then replays it into the processor's program
// memory as CLEAR / gap-free BURST / FINISH and releases the processor to RUN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2*W-1:0]   in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             reload,
  output logic             mem_write,
  output logic             PC_reset,
  output logic [W-1:0]     instr,
  output logic [W-1:0]     portin,
  output logic             done,
  output logic [LEN_W-1:0] prog_len,
  output logic             err_overflow
);
  localparam int CW = $clog2(DEPTH + 1);

  state_t         state, state_nx;
  logic [CW-1:0]  count, rd_ptr;
  logic [2*W-1:0] rd_data;
  logic           accept, at_limit, rd_en, clr;
  logic           mem_write_nx, pc_reset_nx, done_nx;
  logic [W-1:0]   instr_nx, portin_nx;

  assign in_ready = (state == IDLE) || (state == COLLECT);
  assign accept   = in_valid && in_ready;
  assign at_limit = (count == CW'(DEPTH - 1));
  assign clr      = (state == RUN) && reload;
  assign prog_len = LEN_W'(count);

  prog_buffer #(.DEPTH(DEPTH), .DW(2*W)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .wr_en   (accept),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_nx     = state;
    rd_en        = 1'b0;
    mem_write_nx = 1'b0;
    pc_reset_nx  = 1'b0;
    done_nx      = 1'b0;
    instr_nx     = '0;
    portin_nx    = '0;
    case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          if (in_last || at_limit) begin
            state_nx    = CLEAR;
            pc_reset_nx = 1'b1;
          end else begin
            state_nx = COLLECT;
          end
        end
      end
      CLEAR, BURST: begin
        if (rd_ptr == count) begin
          state_nx    = FINISH;
          pc_reset_nx = 1'b1;
        end else begin
          state_nx     = BURST;
          rd_en        = 1'b1;
          mem_write_nx = 1'b1;
          instr_nx     = rd_data[OPC_LSB +: W];
          portin_nx    = rd_data[OPC_LSB + W +: W];
        end
      end
      FINISH: begin
        state_nx = RUN;
        done_nx  = 1'b1;
      end
      RUN: begin
        if (reload) state_nx = IDLE;
        else        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_write <= 1'b0;
      PC_reset  <= 1'b0;
      instr     <= '0;
      portin    <= '0;
      done      <= 1'b0;
    end else begin
      mem_write <= mem_write_nx;
      PC_reset  <= pc_reset_nx;
      instr     <= instr_nx;
      portin    <= portin_nx;
      done      <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr)                        err_overflow <= 1'b0;
    else if (accept && at_limit && !in_last) err_overflow <= 1'b1;
  end
endmodule
